multicycle_control: RTL and testbench

//  Multicycle sequencer for the LEGv8 datapath: FETCH/DECODE/EXEC/MEM/WB FSM driving
//  PC, IR, register file, ALU mux and data-memory strobes. It replaces the single-cycle

---
 rtl/multicycle_control.sv | 159 +++++++++++++++
 tb/tb_multicycle_control.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multicycle LEGv8 sequencer: FETCH/DECODE/EXEC/MEM/WB state machine that
// drives datapath enables, mux selects and data-memory strobes.
module multicycle_control #(
    parameter int WAIT_MAX = 15
) (
    input  logic        iCLK,
    input  logic        iReset,
    input  logic [10:0] iOpcode,
    input  logic        iZero,
    input  logic        iMemReady,
    output logic        oPCWrite,
    output logic        oIRWrite,
    output logic        oReg2Loc,
    output logic        oALUSrcA,
    output logic [1:0]  oALUSrcB,
    output logic [1:0]  oALUOp,
    output logic        oMemRead,
    output logic        oMemWrite,
    output logic        oMemtoReg,
    output logic        oRegWrite,
    output logic [1:0]  oOrigemPC,
    output logic [3:0]  oState,
    output logic        oFault
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC_R = 4'd2,
        S_WB_R   = 4'd3,
        S_ADDR   = 4'd4,
        S_MEM_RD = 4'd5,
        S_MEM_WR = 4'd6,
        S_WB_LD  = 4'd7,
        S_BR_CBZ = 4'd8,
        S_BR_B   = 4'd9,
        S_FAULT  = 4'd15
    } state_t;

    state_t     state;
    logic [7:0] wait_cnt;

    logic is_ldur, is_stur, is_rtype, is_cbz, is_b;
    logic timeout;

    assign is_ldur  = (iOpcode == 11'b11111000010);
    assign is_stur  = (iOpcode == 11'b11111000000);
    assign is_rtype = (iOpcode == 11'b10001011000) ||
                      (iOpcode == 11'b11001011000) ||
                      (iOpcode == 11'b10001010000) ||
                      (iOpcode == 11'b10101010000);
    assign is_cbz   = (iOpcode[10:3] == 8'b10110100);
    assign is_b     = (iOpcode[10:5] == 6'b000101);
    assign timeout  = (wait_cnt == 8'(WAIT_MAX));

    // The counter clears on every transition, so it only ever accumulates
    // while a memory-wait state is holding for iMemReady.
    always_ff @(posedge iCLK or posedge iReset) begin
        if (iReset) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
        end else begin
            wait_cnt <= '0;
            unique case (state)
                S_FETCH, S_MEM_RD, S_MEM_WR: begin
                    if (iMemReady) begin
                        unique case (state)
                            S_FETCH:  state <= S_DECODE;
                            S_MEM_RD: state <= S_WB_LD;
                            default:  state <= S_FETCH;
                        endcase
                    end else if (timeout) begin
                        state <= S_FAULT;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_DECODE: begin
                    if (is_rtype)                state <= S_EXEC_R;
                    else if (is_ldur || is_stur) state <= S_ADDR;
                    else if (is_cbz)             state <= S_BR_CBZ;
                    else if (is_b)               state <= S_BR_B;
                    else                         state <= S_FAULT;
                end
                S_EXEC_R: state <= S_WB_R;
                S_ADDR: begin
                    if (is_ldur)      state <= S_MEM_RD;
                    else if (is_stur) state <= S_MEM_WR;
                    else              state <= S_FAULT;
                end
                S_WB_R, S_WB_LD, S_BR_CBZ, S_BR_B: state <= S_FETCH;
                S_FAULT: state <= S_FAULT;
                default: state <= S_FAULT;
            endcase
        end
    end

    always_comb begin
        oPCWrite  = 1'b0;
        oIRWrite  = 1'b0;
        oReg2Loc  = 1'b0;
        oALUSrcA  = 1'b0;
        oALUSrcB  = 2'b00;
        oALUOp    = 2'b00;
        oMemRead  = 1'b0;
        oMemWrite = 1'b0;
        oMemtoReg = 1'b0;
        oRegWrite = 1'b0;
        oOrigemPC = 2'b00;
        oFault    = 1'b0;
        unique case (state)
            S_FETCH: begin
                oMemRead = 1'b1;
                oALUSrcB = 2'b01;
                oPCWrite = iMemReady;
                oIRWrite = iMemReady;
            end
            S_DECODE: begin
                oALUSrcB = 2'b11;
                oReg2Loc = is_stur || is_cbz;
            end
            S_EXEC_R: begin
                oALUSrcA = 1'b1;
                oALUOp   = 2'b10;
            end
            S_WB_R: oRegWrite = 1'b1;
            S_ADDR: begin
                oALUSrcA = 1'b1;
                oALUSrcB = 2'b10;
                oReg2Loc = 1'b1;
            end
            S_MEM_RD: oMemRead = 1'b1;
            S_MEM_WR: begin
                oMemWrite = 1'b1;
                oReg2Loc  = 1'b1;
            end
            S_WB_LD: begin
                oRegWrite = 1'b1;
                oMemtoReg = 1'b1;
            end
            S_BR_CBZ: begin
                oReg2Loc  = 1'b1;
                oALUSrcA  = 1'b1;
                oALUOp    = 2'b01;
                oOrigemPC = 2'b01;
                oPCWrite  = iZero;
            end
            S_BR_B: begin
                oOrigemPC = 2'b01;
                oPCWrite  = 1'b1;
            end
            S_FAULT: oFault = 1'b1;
            default: ;
        endcase
    end

    assign oState = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: per-instruction cycle traces
// built from the instruction's class and planned memory waits.
module tb_multicycle_control;

    localparam int WAIT_MAX = 15;

    localparam int C_R   = 0;
    localparam int C_LD  = 1;
    localparam int C_ST  = 2;
    localparam int C_CBZ = 3;
    localparam int C_B   = 4;
    localparam int C_ILL = 5;

    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;

    logic        iCLK = 1'b0;
    logic        iReset = 1'b1;
    logic [10:0] iOpcode = '0;
    logic        iZero = 1'b0;
    logic        iMemReady = 1'b0;
    logic        oPCWrite, oIRWrite, oReg2Loc, oALUSrcA;
    logic [1:0]  oALUSrcB, oALUOp, oOrigemPC;
    logic        oMemRead, oMemWrite, oMemtoReg, oRegWrite, oFault;
    logic [3:0]  oState;

    int checks = 0;
    int errors = 0;

    always #5 iCLK = ~iCLK;

    multicycle_control #(.WAIT_MAX(WAIT_MAX)) dut (
        .iCLK(iCLK), .iReset(iReset), .iOpcode(iOpcode), .iZero(iZero),
        .iMemReady(iMemReady), .oPCWrite(oPCWrite), .oIRWrite(oIRWrite),
        .oReg2Loc(oReg2Loc), .oALUSrcA(oALUSrcA), .oALUSrcB(oALUSrcB),
        .oALUOp(oALUOp), .oMemRead(oMemRead), .oMemWrite(oMemWrite),
        .oMemtoReg(oMemtoReg), .oRegWrite(oRegWrite), .oOrigemPC(oOrigemPC),
        .oState(oState), .oFault(oFault)
    );

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [14:0] dut_vec();
        return {oPCWrite, oIRWrite, oReg2Loc, oALUSrcA, oALUSrcB, oALUOp,
                oMemRead, oMemWrite, oMemtoReg, oRegWrite, oOrigemPC, oFault};
    endfunction

    // Expected control word for a state, straight from the state table
    function automatic logic [14:0] ref_vec(int st, bit rdy, bit z, int cls);
        logic pcw = 0, irw = 0, r2l = 0, asa = 0;
        logic [1:0] asb = 0, aop = 0, opc = 0;
        logic mr = 0, mw = 0, m2r = 0, rw = 0, flt = 0;
        case (st)
            0:  begin mr = 1; asb = 2'b01; pcw = rdy; irw = rdy; end
            1:  begin asb = 2'b11; r2l = (cls == C_ST || cls == C_CBZ); end
            2:  begin asa = 1; aop = 2'b10; end
            3:  rw = 1;
            4:  begin asa = 1; asb = 2'b10; r2l = 1; end
            5:  mr = 1;
            6:  begin mw = 1; r2l = 1; end
            7:  begin rw = 1; m2r = 1; end
            8:  begin r2l = 1; asa = 1; aop = 2'b01; opc = 2'b01; pcw = z; end
            9:  begin opc = 2'b01; pcw = 1; end
            15: flt = 1;
            default: ;
        endcase
        return {pcw, irw, r2l, asa, asb, aop, mr, mw, m2r, rw, opc, flt};
    endfunction

    function automatic bit is_legal(logic [10:0] op);
        return op == OP_LDUR || op == OP_STUR || op == OP_ADD ||
               op == OP_SUB || op == OP_AND || op == OP_ORR ||
               op[10:3] == 8'b10110100 || op[10:5] == 6'b000101;
    endfunction

    function automatic logic [10:0] gen_op(int cls);
        logic [10:0] op;
        case (cls)
            C_R: begin
                case ($urandom_range(0, 3))
                    0: op = OP_ADD;
                    1: op = OP_SUB;
                    2: op = OP_AND;
                    default: op = OP_ORR;
                endcase
            end
            C_LD:  op = OP_LDUR;
            C_ST:  op = OP_STUR;
            C_CBZ: op = {8'b10110100, 3'($urandom)};
            C_B:   op = {6'b000101, 5'($urandom)};
            default: begin
                op = 11'($urandom);
                while (is_legal(op)) op = 11'($urandom);
            end
        endcase
        return op;
    endfunction

    function automatic int pick_wait();
        int r = $urandom_range(0, 19);
        if (r < 14) return r % 4;
        if (r < 16) return WAIT_MAX;
        if (r < 18) return $urandom_range(4, WAIT_MAX - 1);
        return WAIT_MAX + 1;
    endfunction

    // One clock: entered at a negedge, drive, sample 1 ns later, move on
    task automatic cyc(int st, bit rdy, bit z, int cls, string tag);
        iMemReady = rdy;
        iZero = z;
        #1;
        check({tag, "_state"}, 32'(oState), 32'(st));
        check({tag, "_outs"}, 32'(dut_vec()), 32'(ref_vec(st, rdy, z, cls)));
        if (oMemRead && oMemWrite) check({tag, "_rdwr"}, 32'd1, 32'd0);
        @(negedge iCLK);
    endtask

    task automatic do_reset(string tag);
        iReset = 1'b1;
        iMemReady = 1'b0;
        #1;
        check({tag, "_rst_state"}, 32'(oState), 32'd0);
        check({tag, "_rst_outs"}, 32'(dut_vec()), 32'(ref_vec(0, 0, 0, C_R)));
        @(negedge iCLK);
        iReset = 1'b0;
    endtask

    // A memory phase with w not-ready cycles; beyond WAIT_MAX it times out
    task automatic mem_phase(int st, int w, int cls, string tag, output bit faulted);
        faulted = 0;
        if (w > WAIT_MAX) begin
            for (int i = 0; i <= WAIT_MAX; i++) cyc(st, 0, 1'($urandom), cls, tag);
            faulted = 1;
        end else begin
            for (int i = 0; i < w; i++) cyc(st, 0, 1'($urandom), cls, tag);
            cyc(st, 1, 1'($urandom), cls, tag);
        end
    endtask

    task automatic run_fault(string tag);
        for (int i = 0; i < 3; i++) cyc(15, 1'($urandom), 1'($urandom), C_ILL, tag);
        do_reset(tag);
    endtask

    task automatic run_instr(int cls, logic [10:0] op, int fw, int mw, bit z, string tag);
        bit f;
        iOpcode = 11'($urandom);
        mem_phase(0, fw, cls, {tag, "_fetch"}, f);
        if (f) begin run_fault({tag, "_ftout"}); return; end
        iOpcode = op;
        cyc(1, 1'($urandom), 1'($urandom), cls, {tag, "_dec"});
        case (cls)
            C_R: begin
                cyc(2, 1'($urandom), 1'($urandom), cls, {tag, "_exec"});
                cyc(3, 1'($urandom), 1'($urandom), cls, {tag, "_wbr"});
            end
            C_LD: begin
                cyc(4, 1'($urandom), 1'($urandom), cls, {tag, "_addr"});
                mem_phase(5, mw, cls, {tag, "_memrd"}, f);
                if (f) run_fault({tag, "_rdtout"});
                else cyc(7, 1'($urandom), 1'($urandom), cls, {tag, "_wbld"});
            end
            C_ST: begin
                cyc(4, 1'($urandom), 1'($urandom), cls, {tag, "_addr"});
                mem_phase(6, mw, cls, {tag, "_memwr"}, f);
                if (f) run_fault({tag, "_wrtout"});
            end
            C_CBZ: cyc(8, 1'($urandom), z, cls, {tag, "_cbz"});
            C_B:   cyc(9, 1'($urandom), 1'($urandom), cls, {tag, "_b"});
            default: run_fault({tag, "_ill"});
        endcase
    endtask

    initial begin
        @(negedge iCLK);
        do_reset("init");

        run_instr(C_R, OP_ADD, 0, 0, 0, "add");
        run_instr(C_LD, OP_LDUR, 0, 3, 0, "ldur_w3");
        run_instr(C_ST, OP_STUR, 2, 1, 0, "stur");
        run_instr(C_CBZ, 11'b10110100101, 0, 0, 1, "cbz_t");
        run_instr(C_CBZ, 11'b10110100010, 0, 0, 0, "cbz_n");
        run_instr(C_B, 11'b00010111010, 0, 0, 0, "b");
        run_instr(C_ILL, 11'h7FF, 0, 0, 0, "ill");
        run_instr(C_R, OP_SUB, WAIT_MAX + 1, 0, 0, "ftout");
        run_instr(C_R, OP_ORR, WAIT_MAX, 0, 0, "fedge");
        run_instr(C_LD, OP_LDUR, 0, WAIT_MAX, 0, "rdedge");

        // Asynchronous reset while a store waits for memory
        iOpcode = OP_STUR;
        cyc(0, 1, 0, C_ST, "arst_fetch");
        cyc(1, 0, 0, C_ST, "arst_dec");
        cyc(4, 0, 0, C_ST, "arst_addr");
        iMemReady = 1'b0;
        #1;
        check("arst_memwr_on", 32'(oMemWrite), 32'd1);
        #2;
        iReset = 1'b1;
        #1;
        check("arst_memwr_off", 32'(oMemWrite), 32'd0);
        check("arst_state", 32'(oState), 32'd0);
        @(negedge iCLK);
        iReset = 1'b0;

        for (int n = 0; n < 300; n++) begin
            int cls;
            int r = $urandom_range(0, 19);
            if (r < 5) cls = C_R;
            else if (r < 9) cls = C_LD;
            else if (r < 13) cls = C_ST;
            else if (r < 16) cls = C_CBZ;
            else if (r < 19) cls = C_B;
            else cls = C_ILL;
            run_instr(cls, gen_op(cls), pick_wait(), pick_wait(),
                      1'($urandom), "rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
